// File: rtl/ctrl_microondas_gen2_if.sv
// Control/status bundle of the microwave controller: front-panel inputs in,
// binary time/power/state status out (display muxing sits downstream).
interface ctrl_microondas_gen2_if;
  logic       start;
  logic       stop;
  logic       pause;
  logic       inc;
  logic       dec;
  logic       door;
  logic       sel_power;
  logic [1:0] step_sel;

  logic [1:0] state_o;
  logic [6:0] min_o;
  logic [5:0] sec_o;
  logic [2:0] power_o;
  logic       heater_en;
  logic       lamp;
  logic       alarm;
  logic       done_pulse;

  modport master (
    output start, stop, pause, inc, dec, door, sel_power, step_sel,
    input  state_o, min_o, sec_o, power_o, heater_en, lamp, alarm, done_pulse
  );

  modport slave (
    input  start, stop, pause, inc, dec, door, sel_power, step_sel,
    output state_o, min_o, sec_o, power_o, heater_en, lamp, alarm, done_pulse
  );
endinterface

// File: rtl/ctrl_microondas_gen2.sv
// Microwave controller core: min:sec cooking timer, IDLE/RUN/PAUSE/DONE FSM,
// 1 s prescaler and N-level heater duty-cycle generator.
module ctrl_microondas_gen2 #(
  parameter int TICK_DIV   = 100_000_000,
  parameter int MAX_MIN    = 99,
  parameter int N_POWER    = 3,
  parameter int DONE_SECS  = 3,
  parameter int QUICK_SECS = 30
) (
  input  logic                         clock,
  input  logic                         reset,
  ctrl_microondas_gen2_if.slave        bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [6:0] mins;
    logic [5:0] secs;
  } mmss_t;

  localparam int                 PRESC_W    = $clog2(TICK_DIV);
  localparam int                 DONE_W     = $clog2(DONE_SECS + 1);
  localparam int                 MAX_TOTAL  = MAX_MIN * 60 + 59;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
  localparam logic [DONE_W-1:0]  DONE_LAST  = DONE_W'(DONE_SECS - 1);
  localparam logic [2:0]         POWER_TOP  = 3'(N_POWER - 1);

  // ---------------------------------------------------------------------------
  // Time arithmetic helpers (all results saturate inside 00:00 .. MAX_MIN:59)
  // ---------------------------------------------------------------------------
  function automatic int to_total(input mmss_t v);
    return int'(v.mins) * 60 + int'(v.secs);
  endfunction

  function automatic mmss_t from_total(input int total);
    int    t;
    mmss_t r;
    t = total;
    if (t > MAX_TOTAL) t = MAX_TOTAL;
    if (t < 0)         t = 0;
    r.mins = 7'(t / 60);
    r.secs = 6'(t % 60);
    return r;
  endfunction

  // Second steps carry/borrow through the total; minute steps keep the seconds.
  function automatic mmss_t edit_time(input mmss_t v, input logic up,
                                      input logic [1:0] step);
    int    amt;
    int    m;
    mmss_t r;
    amt = step[0] ? 10 : 1;
    r   = v;
    if (!step[1]) begin
      r = from_total(up ? to_total(v) + amt : to_total(v) - amt);
    end else begin
      m = up ? int'(v.mins) + amt : int'(v.mins) - amt;
      if (m > MAX_MIN)  r.mins = 7'(MAX_MIN);
      else if (m < 0)   r = '0;
      else              r.mins = 7'(m);
    end
    return r;
  endfunction

  function automatic mmss_t count_down(input mmss_t v);
    mmss_t r;
    r = v;
    if (v.secs != 6'd0) begin
      r.secs = v.secs - 6'd1;
    end else if (v.mins != 7'd0) begin
      r.mins = v.mins - 7'd1;
      r.secs = 6'd59;
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Button edge detection
  // ---------------------------------------------------------------------------
  logic [5:0] btn_now;
  logic [5:0] btn_q;
  logic       stop_e, pause_e, start_e, inc_e, dec_e, door_e;

  assign btn_now = {bus.door, bus.dec, bus.inc, bus.start, bus.pause, bus.stop};

  // Sampled even while reset is high so a level held across reset is not an edge.
  always_ff @(posedge clock) begin
    btn_q <= btn_now;
  end

  assign {door_e, dec_e, inc_e, start_e, pause_e, stop_e} = btn_now & ~btn_q;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_t             state_q, state_d;
  mmss_t              time_q, time_d;
  logic [2:0]         power_q, power_d;
  logic [PRESC_W-1:0] presc_q;
  logic [2:0]         win_q;
  logic [DONE_W-1:0]  done_cnt_q;
  logic               done_pulse_q;

  logic  tick;
  logic  time_zero;
  logic  edit_req;
  logic  enter_run;
  logic  enter_done;
  mmss_t cd_time;
  logic  cd_zero;

  assign tick      = ((state_q == ST_RUN) || (state_q == ST_DONE)) && (presc_q == PRESC_LAST);
  assign time_zero = (time_q == '0);
  assign edit_req  = inc_e | dec_e;
  assign cd_time   = count_down(time_q);
  assign cd_zero   = (cd_time == '0);

  assign enter_run  = (state_d == ST_RUN)  && (state_q != ST_RUN);
  assign enter_done = (state_d == ST_DONE) && (state_q != ST_DONE);

  // FSM process 1: state register.
  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM process 2: next state. Priority stop > door > pause > start > tick.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!stop_e && start_e && !bus.door) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (stop_e)                        state_d = ST_IDLE;
        else if (bus.door || pause_e)      state_d = ST_PAUSE;
        else if (start_e)                  state_d = ST_RUN;
        else if (tick && cd_zero)          state_d = ST_DONE;
      end
      ST_PAUSE: begin
        if (stop_e)                                     state_d = ST_IDLE;
        else if ((start_e || pause_e) && !bus.door)     state_d = ST_RUN;
      end
      ST_DONE: begin
        if (start_e || stop_e || door_e)                state_d = ST_IDLE;
        else if (tick && (done_cnt_q == DONE_LAST))     state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Time and power next values; inc wins if inc and dec rise together.
  always_comb begin
    time_d  = time_q;
    power_d = power_q;
    unique case (state_q)
      ST_IDLE: begin
        if (stop_e) begin
          time_d = '0;
        end else if (start_e && !bus.door) begin
          if (time_zero) time_d = from_total(QUICK_SECS);
        end else if (edit_req) begin
          if (bus.sel_power) begin
            if (inc_e) power_d = (power_q == POWER_TOP) ? power_q : power_q + 3'd1;
            else       power_d = (power_q == 3'd0)      ? power_q : power_q - 3'd1;
          end else begin
            time_d = edit_time(time_q, inc_e, bus.step_sel);
          end
        end
      end
      ST_RUN: begin
        if (stop_e) begin
          time_d = '0;
        end else if (bus.door || pause_e) begin
          time_d = time_q;
        end else if (start_e) begin
          time_d = from_total(to_total(tick ? cd_time : time_q) + QUICK_SECS);
        end else if (tick) begin
          time_d = cd_time;
        end
      end
      ST_PAUSE: begin
        if (stop_e) begin
          time_d = '0;
        end else if ((start_e || pause_e) && !bus.door) begin
          time_d = time_q;
        end else if (edit_req) begin
          time_d = edit_time(time_q, inc_e, bus.step_sel);
        end
      end
      default: begin
        time_d = time_q;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      time_q  <= '0;
      power_q <= POWER_TOP;
    end else begin
      time_q  <= time_d;
      power_q <= power_d;
    end
  end

  // Prescaler, duty-cycle window and alarm length counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      presc_q      <= '0;
      win_q        <= '0;
      done_cnt_q   <= '0;
      done_pulse_q <= 1'b0;
    end else begin
      done_pulse_q <= enter_done;

      if (enter_run || enter_done)                       presc_q <= '0;
      else if (tick)                                     presc_q <= '0;
      else if ((state_q == ST_RUN) || (state_q == ST_DONE)) presc_q <= presc_q + 1'b1;

      if (enter_run)                         win_q <= '0;
      else if ((state_q == ST_RUN) && tick)  win_q <= (win_q == POWER_TOP) ? 3'd0 : win_q + 3'd1;

      if (enter_done)                        done_cnt_q <= '0;
      else if ((state_q == ST_DONE) && tick) done_cnt_q <= done_cnt_q + 1'b1;
    end
  end

  // FSM process 3: outputs. The door interlock on the heater is purely combinational.
  always_comb begin
    bus.state_o    = state_q;
    bus.min_o      = time_q.mins;
    bus.sec_o      = time_q.secs;
    bus.power_o    = power_q;
    bus.heater_en  = (state_q == ST_RUN) && !bus.door && (win_q <= power_q);
    bus.lamp       = bus.door || (state_q != ST_IDLE);
    bus.alarm      = (state_q == ST_DONE);
    bus.done_pulse = done_pulse_q;
  end

endmodule

// File: tb/tb_ctrl_microondas_gen2.sv
// Self-checking bench for ctrl_microondas_gen2: table-driven edit vectors plus
// hand-written timing sequences for countdown, pause/resume, heater and reset.
module tb_ctrl_microondas_gen2;

  localparam int TICK_DIV   = 4;
  localparam int MAX_MIN    = 99;
  localparam int N_POWER    = 3;
  localparam int DONE_SECS  = 3;
  localparam int QUICK_SECS = 30;

  localparam logic [4:0] B_START = 5'b10000;
  localparam logic [4:0] B_STOP  = 5'b01000;
  localparam logic [4:0] B_PAUSE = 5'b00100;
  localparam logic [4:0] B_INC   = 5'b00010;
  localparam logic [4:0] B_DEC   = 5'b00001;

  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;

  ctrl_microondas_gen2_if bus ();

  ctrl_microondas_gen2 #(
    .TICK_DIV  (TICK_DIV),
    .MAX_MIN   (MAX_MIN),
    .N_POWER   (N_POWER),
    .DONE_SECS (DONE_SECS),
    .QUICK_SECS(QUICK_SECS)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [4:0] btn;
    logic       door;
    logic       sel_power;
    logic [1:0] step_sel;
    int         reps;
    int         exp_state;
    int         exp_min;
    int         exp_sec;
    int         exp_power;
    int         exp_lamp;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic [4:0] btn, input logic door, input logic sel_power,
                              input logic [1:0] step_sel, input int reps, input int st,
                              input int mn, input int sc, input int pw, input int lamp);
    vec_t v;
    v.btn = btn; v.door = door; v.sel_power = sel_power; v.step_sel = step_sel;
    v.reps = reps; v.exp_state = st; v.exp_min = mn; v.exp_sec = sc;
    v.exp_power = pw; v.exp_lamp = lamp;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the active edge; outputs are sampled there too.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic press(input logic [4:0] btn, input int reps);
    for (int i = 0; i < reps; i++) begin
      {bus.start, bus.stop, bus.pause, bus.inc, bus.dec} = btn;
      step();
      {bus.start, bus.stop, bus.pause, bus.inc, bus.dec} = 5'b0;
      step();
    end
  endtask

  task automatic check_time(input string tag, input int st, input int mn, input int sc);
    check({tag, " state"}, bus.state_o, st);
    check({tag, " min"},   bus.min_o,   mn);
    check({tag, " sec"},   bus.sec_o,   sc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    {bus.start, bus.stop, bus.pause, bus.inc, bus.dec} = 5'b0;
    bus.door = 1'b0; bus.sel_power = 1'b0; bus.step_sel = 2'b00;

    // Edit vectors, applied in order from the reset state.
    vq.push_back(mk(B_START, 1, 0, 2'b00,  1, S_IDLE,  0,  0, 2, 1));
    vq.push_back(mk(B_INC,   0, 0, 2'b11, 10, S_IDLE, 99,  0, 2, 0));
    vq.push_back(mk(B_INC,   0, 0, 2'b00, 60, S_IDLE, 99, 59, 2, 0));
    vq.push_back(mk(B_STOP,  0, 0, 2'b00,  1, S_IDLE,  0,  0, 2, 0));
    vq.push_back(mk(B_INC,   0, 0, 2'b00,  5, S_IDLE,  0,  5, 2, 0));
    vq.push_back(mk(B_DEC,   0, 0, 2'b01,  1, S_IDLE,  0,  0, 2, 0));
    vq.push_back(mk(B_INC,   0, 0, 2'b10,  1, S_IDLE,  1,  0, 2, 0));
    vq.push_back(mk(B_DEC,   0, 0, 2'b00,  1, S_IDLE,  0, 59, 2, 0));
    vq.push_back(mk(B_INC,   0, 0, 2'b01,  1, S_IDLE,  1,  9, 2, 0));
    vq.push_back(mk(B_DEC,   0, 1, 2'b00,  1, S_IDLE,  1,  9, 1, 0));
    vq.push_back(mk(B_DEC,   0, 1, 2'b00,  3, S_IDLE,  1,  9, 0, 0));
    vq.push_back(mk(B_INC,   0, 1, 2'b00,  1, S_IDLE,  1,  9, 1, 0));
    vq.push_back(mk(B_INC,   0, 1, 2'b00,  5, S_IDLE,  1,  9, 2, 0));
    vq.push_back(mk(B_DEC,   0, 0, 2'b10,  1, S_IDLE,  0,  9, 2, 0));
    vq.push_back(mk(B_DEC,   0, 0, 2'b10,  1, S_IDLE,  0,  0, 2, 0));
    vq.push_back(mk(B_INC,   0, 0, 2'b11, 10, S_IDLE, 99,  0, 2, 0));
    vq.push_back(mk(B_INC,   0, 0, 2'b01,  6, S_IDLE, 99, 59, 2, 0));
    vq.push_back(mk(B_STOP,  0, 0, 2'b00,  1, S_IDLE,  0,  0, 2, 0));

    // Reset state.
    repeat (3) step();
    check_time("reset", S_IDLE, 0, 0);
    check("reset power",  bus.power_o,    2);
    check("reset heater", bus.heater_en,  0);
    check("reset lamp",   bus.lamp,       0);
    check("reset alarm",  bus.alarm,      0);
    check("reset pulse",  bus.done_pulse, 0);
    reset = 1'b0;
    step();

    foreach (vq[i]) begin
      bus.door      = vq[i].door;
      bus.sel_power = vq[i].sel_power;
      bus.step_sel  = vq[i].step_sel;
      press(vq[i].btn, vq[i].reps);
      check_time($sformatf("vec%0d", i), vq[i].exp_state, vq[i].exp_min, vq[i].exp_sec);
      check($sformatf("vec%0d power", i), bus.power_o, vq[i].exp_power);
      check($sformatf("vec%0d lamp", i),  bus.lamp,    vq[i].exp_lamp);
    end
    bus.door = 1'b0; bus.sel_power = 1'b0; bus.step_sel = 2'b00;

    // 00:03 countdown, DONE for 12 cycles, back to IDLE.
    press(B_INC, 3);
    bus.start = 1'b1; step(); bus.start = 1'b0;
    check_time("cd c0", S_RUN, 0, 3);
    for (int c = 1; c <= 24; c++) begin
      step();
      check($sformatf("cd c%0d state", c), bus.state_o,
            (c < 12) ? S_RUN : (c < 24) ? S_DONE : S_IDLE);
      check($sformatf("cd c%0d sec", c), bus.sec_o, (c < 12) ? 3 - c / 4 : 0);
      check($sformatf("cd c%0d pulse", c), bus.done_pulse, (c == 12) ? 1 : 0);
      check($sformatf("cd c%0d alarm", c), bus.alarm, (c >= 12 && c < 24) ? 1 : 0);
    end

    // Quick start from 00:00 and +30 s while running.
    bus.start = 1'b1; step(); bus.start = 1'b0;
    check_time("quick load", S_RUN, 0, 30);
    repeat (4) step();
    check_time("quick tick", S_RUN, 0, 29);
    bus.start = 1'b1; step(); bus.start = 1'b0;
    check_time("quick add", S_RUN, 0, 59);
    bus.stop = 1'b1; step(); bus.stop = 1'b0;
    check_time("quick stop", S_IDLE, 0, 0);

    // Door interlock, pause freeze, resume from a full tick.
    bus.step_sel = 2'b10;
    press(B_INC, 1);
    bus.step_sel = 2'b00;
    bus.start = 1'b1; step(); bus.start = 1'b0;
    step(); step();
    check("door pre heater", bus.heater_en, 1);
    bus.door = 1'b1; #1;
    check("door same-cycle heater", bus.heater_en, 0);
    check("door same-cycle state",  bus.state_o,   S_RUN);
    step();
    check_time("door pause", S_PAUSE, 1, 0);
    repeat (6) step();
    check_time("pause frozen", S_PAUSE, 1, 0);
    check("pause lamp", bus.lamp, 1);
    bus.door = 1'b0; step();
    bus.pause = 1'b1; step(); bus.pause = 1'b0;
    check_time("resume", S_RUN, 1, 0);
    repeat (3) step();
    check_time("resume c3", S_RUN, 1, 0);
    step();
    check_time("resume c4", S_RUN, 0, 59);
    press(B_STOP, 1);

    // Power 0 duty pattern 1,0,0 per tick; power locked in RUN; combined stop.
    bus.sel_power = 1'b1; press(B_DEC, 2); bus.sel_power = 1'b0;
    check("pwr low", bus.power_o, 0);
    bus.step_sel = 2'b01; press(B_INC, 1); bus.step_sel = 2'b00;
    bus.start = 1'b1; step(); bus.start = 1'b0;
    for (int c = 0; c < 16; c++) begin
      check($sformatf("duty0 c%0d", c), bus.heater_en, ((c / 4) % 3 == 0) ? 1 : 0);
      step();
    end
    bus.sel_power = 1'b1; press(B_INC, 1); bus.sel_power = 1'b0;
    check("pwr locked in run", bus.power_o, 0);
    {bus.start, bus.stop, bus.pause} = 3'b111; step(); {bus.start, bus.stop, bus.pause} = 3'b000;
    check_time("combined stop", S_IDLE, 0, 0);
    check("combined stop heater", bus.heater_en, 0);

    // Top power level keeps the heater on; then reset while running.
    bus.sel_power = 1'b1; press(B_INC, 2); bus.sel_power = 1'b0;
    bus.step_sel = 2'b01; press(B_INC, 1); bus.step_sel = 2'b00;
    bus.start = 1'b1; step(); bus.start = 1'b0;
    for (int c = 0; c < 16; c++) begin
      check($sformatf("duty2 c%0d", c), bus.heater_en, 1);
      step();
    end
    reset = 1'b1; step();
    check_time("rst run", S_IDLE, 0, 0);
    check("rst run power",  bus.power_o,   2);
    check("rst run heater", bus.heater_en, 0);
    reset = 1'b0; step();

    // Reset while in DONE with a non-default power level.
    bus.sel_power = 1'b1; press(B_DEC, 2); bus.sel_power = 1'b0;
    press(B_INC, 1);
    bus.start = 1'b1; step(); bus.start = 1'b0;
    repeat (4) step();
    check("pre-rst done state", bus.state_o, S_DONE);
    reset = 1'b1; step();
    check_time("rst done", S_IDLE, 0, 0);
    check("rst done power", bus.power_o,    2);
    check("rst done alarm", bus.alarm,      0);
    check("rst done pulse", bus.done_pulse, 0);
    reset = 1'b0; step();

    // DONE acknowledged by a door-open edge.
    press(B_INC, 1);
    bus.start = 1'b1; step(); bus.start = 1'b0;
    repeat (4) step();
    check("ack pre state", bus.state_o, S_DONE);
    bus.door = 1'b1; step();
    check("ack state", bus.state_o, S_IDLE);
    check("ack alarm", bus.alarm,   0);
    check("ack lamp",  bus.lamp,    1);
    bus.door = 1'b0; step();
    check("ack lamp off", bus.lamp, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
